// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master port between i_cache (read only) and d_cache (read + write).
// Optional macro ARB_RAW_CHECK_EN holds d_cache reads that hit the line of a pending write.
module cache_axi_arbiter #(
  parameter logic [3:0]  ID_I     = 4'd0,
  parameter logic [3:0]  ID_D     = 4'd1,
  parameter int unsigned LINE_OFF = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam int unsigned TAG_W = 32 - LINE_OFF;

  typedef enum logic [1:0] {RS_IDLE = 2'd0, RS_AR = 2'd1, RS_R = 2'd2} rd_state_e;
  typedef enum logic [1:0] {WS_IDLE = 2'd0, WS_XFER = 2'd1, WS_B = 2'd2} wr_state_e;

  rd_state_e        rs_q, rs_d;
  wr_state_e        ws_q, ws_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [TAG_W-1:0] wr_tag_q, wr_tag_d;
  logic             raw_block;
  logic             i_req, d_req, pick;
  logic             unused_rid;

  assign unused_rid = ^m_rid;

`ifdef ARB_RAW_CHECK_EN
  assign raw_block = (ws_q != WS_IDLE) && (d_araddr[31:LINE_OFF] == wr_tag_q);
`else
  logic unused_wr_tag;
  assign unused_wr_tag = ^wr_tag_q;
  assign raw_block = 1'b0;
`endif

  assign i_req = i_arvalid;
  assign d_req = d_arvalid & ~raw_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q         <= RS_IDLE;
      ws_q         <= WS_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wr_tag_q     <= '0;
    end else begin
      rs_q         <= rs_d;
      ws_q         <= ws_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      wr_tag_q     <= wr_tag_d;
    end
  end

  // Contested requests go to whoever did not win last time.
  always_comb begin
    rs_d         = rs_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    pick         = 1'b0;
    case (rs_q)
      RS_IDLE: begin
        if (i_req | d_req) begin
          pick         = (i_req & d_req) ? ~last_grant_q : d_req;
          grant_d      = pick;
          last_grant_d = pick;
          araddr_d     = pick ? d_araddr : i_araddr;
          arlen_d      = pick ? d_arlen : i_arlen;
          rs_d         = RS_AR;
        end
      end
      RS_AR:   if (m_arready) rs_d = RS_R;
      RS_R:    if (m_rvalid & m_rready & m_rlast) rs_d = RS_IDLE;
      default: rs_d = RS_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid = (rs_q == RS_AR);
    m_araddr  = araddr_q;
    m_arlen   = arlen_q;
    m_arsize  = 3'b010;
    m_arid    = grant_q ? ID_D : ID_I;
    i_arready = m_arvalid & m_arready & ~grant_q;
    d_arready = m_arvalid & m_arready & grant_q;
    m_rready  = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    if (rs_q == RS_R) begin
      m_rready = grant_q ? d_rready : i_rready;
      i_rvalid = m_rvalid & ~grant_q;
      d_rvalid = m_rvalid & grant_q;
    end
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    i_rlast = m_rlast;
    d_rlast = m_rlast;
  end

  // AW and W complete independently; B is only opened once both are done.
  always_comb begin
    ws_d      = ws_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_tag_d  = wr_tag_q;
    case (ws_q)
      WS_IDLE: begin
        if (d_awvalid) begin
          wr_tag_d = d_awaddr[31:LINE_OFF];
          ws_d     = WS_XFER;
        end
      end
      WS_XFER: begin
        if (m_awvalid & m_awready) aw_done_d = 1'b1;
        if (m_wvalid & m_wready & d_wlast) w_done_d = 1'b1;
        if (aw_done_d & w_done_d) ws_d = WS_B;
      end
      WS_B: begin
        if (m_bvalid & m_bready) begin
          ws_d      = WS_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: ws_d = WS_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid = 1'b0;
    d_awready = 1'b0;
    m_wvalid  = 1'b0;
    d_wready  = 1'b0;
    m_bready  = 1'b0;
    d_bvalid  = 1'b0;
    case (ws_q)
      WS_XFER: begin
        m_awvalid = d_awvalid & ~aw_done_q;
        d_awready = m_awready & ~aw_done_q;
        m_wvalid  = d_wvalid & ~w_done_q;
        d_wready  = m_wready & ~w_done_q;
      end
      WS_B: begin
        m_bready = d_bready;
        d_bvalid = m_bvalid;
      end
      default: ;
    endcase
    m_awid   = ID_D;
    m_awaddr = d_awaddr;
    m_awlen  = d_awlen;
    m_awsize = d_awsize;
    m_wdata  = d_wdata;
    m_wstrb  = d_wstrb;
    m_wlast  = d_wlast;
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed testbench for cache_axi_arbiter: read arbitration, AR stall,
// write-back sequencing, read-after-write hold (ARB_RAW_CHECK_EN) and mid-burst reset.
module tb_cache_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata;
  logic [7:0]  i_arlen, d_arlen;
  logic        i_arvalid, d_arvalid, i_arready, d_arready;
  logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
  logic [3:0]  m_arid, m_rid, m_awid;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [31:0] d_awaddr, d_wdata, m_awaddr, m_wdata;
  logic [7:0]  d_awlen, m_awlen;
  logic [2:0]  d_awsize, m_awsize;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Inputs change 2 time units after the rising edge, well clear of it.
  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic [7:0] il,
                               input logic dv, input logic [31:0] da, input logic [7:0] dl);
    i_arvalid = iv; i_araddr = ia; i_arlen = il;
    d_arvalid = dv; d_araddr = da; d_arlen = dl;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 8'h0);
    i_rready = 1'b0; d_rready = 1'b0;
    m_arready = 1'b0; m_rid = 4'h0; m_rdata = 32'h0; m_rlast = 1'b0; m_rvalid = 1'b0;
    d_awaddr = 32'h0; d_awlen = 8'h0; d_awsize = 3'h0; d_awvalid = 1'b0;
    d_wdata = 32'h0; d_wstrb = 4'h0; d_wlast = 1'b0; d_wvalid = 1'b0; d_bready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    stepClock();
    stepClock();
    rst = 1'b0;
  endtask

  // Call just after the edge that should have moved the read FSM to RS_AR.
  task automatic expectAr(input bit g, input logic [31:0] addr, input logic [7:0] len);
    checkOutput("ar_valid", m_arvalid, 1);
    checkOutput("ar_id", m_arid, g ? 32'd1 : 32'd0);
    checkOutput("ar_addr", m_araddr, addr);
    checkOutput("ar_len", m_arlen, len);
  endtask

  task automatic arHandshake(input bit g, input bit dropReq);
    m_arready = 1'b1;
    #1;
    checkOutput("arready_i", i_arready, g ? 32'd0 : 32'd1);
    checkOutput("arready_d", d_arready, g ? 32'd1 : 32'd0);
    stepClock();
    m_arready = 1'b0;
    if (dropReq) begin
      if (g) d_arvalid = 1'b0;
      else   i_arvalid = 1'b0;
    end
  endtask

  task automatic oneBeat(input bit g, input logic [31:0] data);
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = data;
    i_rready = 1'b1; d_rready = 1'b1;
    #1;
    checkOutput("beat_rvalid_i", i_rvalid, g ? 32'd0 : 32'd1);
    checkOutput("beat_rvalid_d", d_rvalid, g ? 32'd1 : 32'd0);
    checkOutput("beat_rdata", g ? d_rdata : i_rdata, data);
    stepClock();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checkOutput("idle_gap_arvalid", m_arvalid, 0);
  endtask

  task automatic finishWrite();
    m_awready = 1'b1; m_wready = 1'b1; d_wvalid = 1'b1; d_wlast = 1'b1;
    #1;
    checkOutput("raw_awready", d_awready, 1);
    checkOutput("raw_wready", d_wready, 1);
    stepClock();
    m_awready = 1'b0; m_wready = 1'b0; d_wvalid = 1'b0; d_wlast = 1'b0; d_awvalid = 1'b0;
    m_bvalid = 1'b1; d_bready = 1'b1;
    stepClock();
    m_bvalid = 1'b0;
  endtask

  initial begin
    clearInputs();
    applyReset();
    checkOutput("rst_arvalid", m_arvalid, 0);
    checkOutput("rst_araddr", m_araddr, 0);
    checkOutput("rst_awvalid", m_awvalid, 0);
    checkOutput("rst_rready", m_rready, 0);
    checkOutput("rst_bready", m_bready, 0);

    $display("[TB] i_cache 8-beat burst");
    applyStimulus(1'b1, 32'h1FC0_0000, 8'd7, 1'b0, 32'h0, 8'h0);
    #1;
    checkOutput("t1_arvalid_same_cycle", m_arvalid, 0);
    stepClock();
    expectAr(1'b0, 32'h1FC0_0000, 8'd7);
    checkOutput("t1_arsize", m_arsize, 3'b010);
    arHandshake(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA000_0000 + k; m_rlast = (k == 7); d_rready = 1'b1;
      if (k == 3) begin
        i_rready = 1'b0;
        #1;
        checkOutput("t1_stall_rready", m_rready, 0);
        stepClock();
      end
      i_rready = 1'b1;
      #1;
      checkOutput("t1_rvalid_i", i_rvalid, 1);
      checkOutput("t1_rvalid_d", d_rvalid, 0);
      checkOutput("t1_rready", m_rready, 1);
      checkOutput("t1_rdata", i_rdata, 32'hA000_0000 + k);
      stepClock();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checkOutput("t1_post_rready", m_rready, 0);
    stepClock();
    checkOutput("t1_idle_arvalid", m_arvalid, 0);

    $display("[TB] round robin");
    applyReset();
    applyStimulus(1'b1, 32'h0000_2000, 8'd0, 1'b1, 32'h0000_3000, 8'd0);
    for (int n = 0; n < 4; n++) begin
      stepClock();
      expectAr(n[0] == 1'b0, (n[0] == 1'b0) ? 32'h0000_3000 : 32'h0000_2000, 8'd0);
      arHandshake(n[0] == 1'b0, 1'b0);
      oneBeat(n[0] == 1'b0, 32'h5500_0000 + n);
    end
    clearInputs();

    $display("[TB] AR backpressure");
    applyStimulus(1'b1, 32'h0000_4440, 8'd3, 1'b0, 32'h0, 8'h0);
    stepClock();
    i_arvalid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      checkOutput("t3_arvalid_held", m_arvalid, 1);
      checkOutput("t3_addr_held", m_araddr, 32'h0000_4440);
      checkOutput("t3_no_arready", i_arready, 0);
      stepClock();
    end
    arHandshake(1'b0, 1'b1);
    oneBeat(1'b0, 32'h0BAD_F00D);

    $display("[TB] d_cache write-back");
    d_awvalid = 1'b1; d_awaddr = 32'h0000_1000; d_awlen = 8'd7; d_awsize = 3'b010;
    d_bready = 1'b1;
    #1;
    checkOutput("t4_idle_awvalid", m_awvalid, 0);
    stepClock();
    checkOutput("t4_awvalid", m_awvalid, 1);
    checkOutput("t4_awaddr", m_awaddr, 32'h0000_1000);
    m_wready = 1'b1; d_wvalid = 1'b1; d_wstrb = 4'hF;
    for (int k = 0; k < 8; k++) begin
      d_wdata = 32'hD000_0000 + k; d_wlast = (k == 7);
      #1;
      checkOutput("t4_wvalid", m_wvalid, 1);
      checkOutput("t4_wdata", m_wdata, 32'hD000_0000 + k);
      stepClock();
    end
    #1;
    checkOutput("t4_w_done_gate", m_wvalid, 0);
    checkOutput("t4_w_done_ready", d_wready, 0);
    checkOutput("t4_no_bready_early", m_bready, 0);
    d_wvalid = 1'b0; d_wlast = 1'b0; m_wready = 1'b0;
    m_awready = 1'b1;
    #1;
    checkOutput("t4_awready", d_awready, 1);
    stepClock();
    m_awready = 1'b0; d_awvalid = 1'b0;
    #1;
    checkOutput("t4_bready", m_bready, 1);
    checkOutput("t4_bvalid_low", d_bvalid, 0);
    m_bvalid = 1'b1;
    #1;
    checkOutput("t4_bvalid_mirror", d_bvalid, 1);
    stepClock();
    m_bvalid = 1'b0;
    #1;
    checkOutput("t4_back_idle", m_bready, 0);
    clearInputs();

    $display("[TB] read after write");
    d_awvalid = 1'b1; d_awaddr = 32'h0000_1000; d_awlen = 8'd0; d_awsize = 3'b010;
    stepClock();
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 32'h0000_1004, 8'd0);
`ifdef ARB_RAW_CHECK_EN
    stepClock();
    checkOutput("t5_raw_hold1", m_arvalid, 0);
    stepClock();
    checkOutput("t5_raw_hold2", m_arvalid, 0);
    i_arvalid = 1'b1; i_araddr = 32'h0000_2000;
    stepClock();
    expectAr(1'b0, 32'h0000_2000, 8'd0);
    arHandshake(1'b0, 1'b1);
    oneBeat(1'b0, 32'h1111_2222);
    stepClock();
    checkOutput("t5_raw_hold3", m_arvalid, 0);
    finishWrite();
    checkOutput("t5_raw_hold_b", m_arvalid, 0);
    stepClock();
    expectAr(1'b1, 32'h0000_1004, 8'd0);
    arHandshake(1'b1, 1'b1);
    oneBeat(1'b1, 32'h3333_4444);
`else
    stepClock();
    expectAr(1'b1, 32'h0000_1004, 8'd0);
    arHandshake(1'b1, 1'b1);
    oneBeat(1'b1, 32'h3333_4444);
    finishWrite();
`endif
    clearInputs();

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 32'h0000_6000, 8'd3, 1'b0, 32'h0, 8'h0);
    stepClock();
    arHandshake(1'b0, 1'b1);
    m_rvalid = 1'b1; i_rready = 1'b1;
    #1;
    checkOutput("t6_pre_rready", m_rready, 1);
    rst = 1'b1;
    stepClock();
    checkOutput("t6_rready", m_rready, 0);
    checkOutput("t6_rvalid_i", i_rvalid, 0);
    checkOutput("t6_arvalid", m_arvalid, 0);
    checkOutput("t6_araddr", m_araddr, 0);
    rst = 1'b0; m_rvalid = 1'b0;
    stepClock();
    checkOutput("t6_idle", m_arvalid, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
